// File: rtl/clock_gate_pkg.sv
// clock_gate_pkg
// Shared definitions for the N-channel clock-gating controller:
//   - cg_state_e : per-channel FSM state (2-bit encoding)
//   - DEF_*      : default timing constants used as parameter defaults
//   - st_gate_on / st_ack : decode of the channel outputs from the FSM state
package clock_gate_pkg;

  typedef enum logic [1:0] {
    ST_GATED    = 2'd0,
    ST_WAKING   = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_DRAINING = 2'd3
  } cg_state_e;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int DEF_CNT_W       = 8;

  // The clock is enabled in every state except GATED (DRAINING keeps it
  // running for one last cycle so the block sees ack fall on a live clock).
  function automatic logic st_gate_on(cg_state_e s);
    return s != ST_GATED;
  endfunction

  function automatic logic st_ack(cg_state_e s);
    return s == ST_RUNNING;
  endfunction

endpackage

// File: rtl/clock_gate_channel.sv
// clock_gate_channel
// One gated-clock channel: wake/run/drain FSM, wake and idle counters and
// the falling-edge enable flop that makes the gate glitch-free.
// Ports:
//   clk      in   system clock, all control on the rising edge
//   rst      in   synchronous reset, active-high
//   force_on in   bypass: clock ungated while high (FSM keeps running)
//   req      in   run request, level
//   busy     in   activity indicator from the clocked block
//   state    out  current FSM state (status/debug)
//   clk_out  out  gated clock
module clock_gate_channel
  import clock_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      force_on,
  input  logic      req,
  input  logic      busy,
  output cg_state_e state,
  output logic      clk_out
);

  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_CYCLES);

  cg_state_e        state_nxt;
  logic [CNT_W-1:0] wake_cnt, wake_cnt_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [CNT_W-1:0] idle_inc;
  logic             in_reset;
  logic             en_neg;

  // Saturating increment: the idle counter never wraps.
  assign idle_inc = (idle_cnt == '1) ? idle_cnt : idle_cnt + CNT_W'(1);

  always_comb begin
    state_nxt    = state;
    wake_cnt_nxt = wake_cnt;
    idle_cnt_nxt = idle_cnt;
    case (state)
      ST_GATED: begin
        idle_cnt_nxt = '0;
        if (req) begin
          state_nxt    = ST_WAKING;
          wake_cnt_nxt = WAKE_LOAD;
        end
      end
      ST_WAKING: begin
        // A dropped request aborts the wake with no ack pulse. The counter
        // stops at zero, and the edge that sees zero lands in RUNNING,
        // giving the first ack WAKE_CYCLES+1 edges after the request edge.
        if (!req) begin
          state_nxt    = ST_GATED;
          wake_cnt_nxt = '0;
        end else if (wake_cnt == '0) begin
          state_nxt    = ST_RUNNING;
          idle_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt - CNT_W'(1);
        end
      end
      ST_RUNNING: begin
        if (req || busy) begin
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_inc;
          if (idle_inc >= IDLE_LIMIT) state_nxt = ST_DRAINING;
        end
      end
      ST_DRAINING: begin
        // Always pass through GATED; a request seen here is picked up there.
        state_nxt    = ST_GATED;
        idle_cnt_nxt = '0;
      end
      default: state_nxt = ST_GATED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_GATED;
      wake_cnt <= '0;
      idle_cnt <= '0;
      in_reset <= 1'b1;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      in_reset <= 1'b0;
    end
  end

  // Enable is re-sampled while clk is low, so clk_out can only change
  // state at a rising edge of clk (start of a full pulse) or stay low.
  // in_reset is the registered view of reset, so the bypass is masked from
  // the falling edge after the reset edge for as long as reset is held.
  always_ff @(negedge clk) begin
    en_neg <= st_gate_on(state) | (force_on & ~in_reset);
  end

  assign clk_out = clk & en_neg;

endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
// N-channel clock-gating controller. Each channel owns its FSM and gate;
// this level distributes the global bypass and packs the per-channel buses.
// Handshake: i_req[c] is a level request. o_ack[c] high means o_clock[c] is
// running and stable; it rises WAKE_CYCLES+1 edges after the edge that first
// samples i_req[c] high and falls one cycle before the clock is gated after
// IDLE_CYCLES consecutive cycles with i_req[c]=0 and i_busy[c]=0.
// Ports:
//   i_clock     in   system clock
//   i_reset     in   synchronous reset, active-high
//   i_force_on  in   global bypass, all clocks ungated while high
//   i_req       in   [NUM_CH] run requests
//   i_busy      in   [NUM_CH] activity indicators
//   o_ack       out  [NUM_CH] channel clock usable
//   o_clock     out  [NUM_CH] gated clocks
//   o_gate_on   out  [NUM_CH] registered enable state (status/debug)
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_force_on,
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_busy,
  output logic [NUM_CH-1:0] o_ack,
  output logic [NUM_CH-1:0] o_clock,
  output logic [NUM_CH-1:0] o_gate_on
);

  cg_state_e ch_state [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clock_gate_channel #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .IDLE_CYCLES (IDLE_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk      (i_clock),
      .rst      (i_reset),
      .force_on (i_force_on),
      .req      (i_req[c]),
      .busy     (i_busy[c]),
      .state    (ch_state[c]),
      .clk_out  (o_clock[c])
    );

    assign o_ack[c]     = st_ack(ch_state[c]);
    assign o_gate_on[c] = st_gate_on(ch_state[c]);
  end

endmodule
